// File: rtl/i2s_tx.sv
// i2s_tx: master-mode I2S transmitter fed by a one-entry valid/ready holding register.
// Define I2S_TX_LEFTJ_EN to build the left-justified (zero-slot delay) variant.
module i2s_tx #(
  parameter int CLK_DIV = 8,
  parameter int WIDTH   = 16
) (
  input  logic             clk_sys,
  input  logic             RESET,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             i2s_bclk,
  output logic             i2s_ws,
  output logic             i2s_data,
  output logic             frame_start,
  output logic             underrun
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = $clog2(2 * WIDTH);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * WIDTH - 1);
  localparam logic [SLOT_W-1:0] WS_FIRST  = SLOT_W'(WIDTH);
`ifdef I2S_TX_LEFTJ_EN
  localparam logic [SLOT_W-1:0] LOAD_SLOT = {SLOT_W{1'b0}};
`else
  localparam logic [SLOT_W-1:0] LOAD_SLOT = SLOT_W'(1);
`endif

  logic [DIV_W-1:0]   div_q, div_d;
  logic               bclk_q, bclk_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               ws_q, ws_d;
  logic               data_q, data_d;
  logic               frame_start_q, frame_start_d;
  logic               underrun_q, underrun_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   hold_l_q, hold_l_d;
  logic [WIDTH-1:0]   hold_r_q, hold_r_d;
  logic [2*WIDTH-1:0] shift_q, shift_d;
  logic               bclk_fall;
  logic               load;
  logic               accept;

  // Next-state logic: divider, slot sequencing, serializer and holding register.
  always_comb begin
    div_d         = div_q;
    bclk_d        = bclk_q;
    slot_d        = slot_q;
    ws_d          = ws_q;
    data_d        = data_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    ready_d       = ready_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    shift_d       = shift_q;
    bclk_fall     = 1'b0;
    load          = 1'b0;
    accept        = sample_valid & ready_q;

    if (div_q == DIV_LAST) begin
      div_d     = {DIV_W{1'b0}};
      bclk_d    = ~bclk_q;
      bclk_fall = bclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // WS/DATA change only with the falling edge so they are stable at the next rise.
    if (bclk_fall) begin
      if (slot_q == SLOT_LAST) begin
        slot_d = {SLOT_W{1'b0}};
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
      ws_d          = (slot_d >= WS_FIRST);
      frame_start_d = (slot_d == {SLOT_W{1'b0}});
      load          = (slot_d == LOAD_SLOT);
      if (load) begin
        underrun_d = ready_q;
        shift_d    = ready_q ? {(2*WIDTH){1'b0}} : {hold_l_q, hold_r_q};
      end else begin
        shift_d = {shift_q[2*WIDTH-2:0], 1'b0};
      end
      data_d = shift_d[2*WIDTH-1];
    end else begin
      slot_d = slot_q;
    end

    // Load looks at the holding state before any same-cycle write.
    if (load && !ready_q) begin
      ready_d = 1'b1;
    end else begin
      ready_d = ready_q;
    end
    if (accept) begin
      hold_l_d = sample_l;
      hold_r_d = sample_r;
      ready_d  = 1'b0;
    end else begin
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      div_q         <= {DIV_W{1'b0}};
      bclk_q        <= 1'b0;
      slot_q        <= SLOT_LAST;
      ws_q          <= 1'b0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ready_q       <= 1'b1;
      hold_l_q      <= {WIDTH{1'b0}};
      hold_r_q      <= {WIDTH{1'b0}};
      shift_q       <= {(2*WIDTH){1'b0}};
    end else begin
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      slot_q        <= slot_d;
      ws_q          <= ws_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      ready_q       <= ready_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      shift_q       <= shift_d;
    end
  end

  assign sample_ready = ready_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_ws       = ws_q;
  assign i2s_data     = data_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with a time-based frame model (CLK_DIV=2, WIDTH=16).
module tb_i2s_tx;

  localparam int CD    = 2;
  localparam int W     = 16;
  localparam int FRAME = 4 * CD * W;
`ifdef I2S_TX_LEFTJ_EN
  localparam int LOAD_SLOT = 0;
`else
  localparam int LOAD_SLOT = 1;
`endif
  localparam int LOAD_OFF = 2 * CD * (LOAD_SLOT + 1);

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_ws;
  logic        i2s_data;
  logic        frame_start;
  logic        underrun;

  i2s_tx #(.CLK_DIV(CD), .WIDTH(W)) dut (
    .clk_sys      (clk_sys),
    .RESET        (RESET),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_ws       (i2s_ws),
    .i2s_data     (i2s_data),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;

  // Model state: edges since reset release, holding register, word played per frame.
  int          m_t;
  bit          m_full;
  logic [31:0] m_hold;
  bit          m_acc;
  int          m_f, m_slot, m_frame;
  logic [31:0] words [0:31];
  logic        exp_bclk, exp_ws, exp_data, exp_fs, exp_un, exp_ready;

  logic [31:0] obs_word [0:31];
  logic [31:0] obs_ws   [0:31];
  logic [31:0] ck_tmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0d)", name, act, want, m_t);
    end
  endtask

  function automatic logic frame_bit(input int j, input int s);
    logic [31:0] w;
`ifdef I2S_TX_LEFTJ_EN
    w = words[j];
    return w[31-s];
`else
    if (s == 0) begin
      if (j == 0) return 1'b0;
      w = words[j-1];
      return w[0];
    end
    w = words[j];
    return w[32-s];
`endif
  endfunction

  task automatic model_step();
    bit fall, load, acc;
    if (RESET) begin
      m_t = 0; m_full = 1'b0; m_hold = 32'h0; m_acc = 1'b0;
      m_f = 0; m_slot = 0; m_frame = 0;
      for (int i = 0; i < 32; i++) words[i] = 32'h0;
      exp_bclk = 1'b0; exp_ws = 1'b0; exp_data = 1'b0;
      exp_fs = 1'b0; exp_un = 1'b0; exp_ready = 1'b1;
    end else begin
      m_t     = m_t + 1;
      fall    = (m_t % (2 * CD)) == 0;
      m_f     = m_t / (2 * CD);
      m_slot  = (m_f == 0) ? 0 : (m_f - 1) % (2 * W);
      m_frame = (m_f == 0) ? 0 : (m_f - 1) / (2 * W);
      load    = fall && (m_f >= 1) && (m_slot == LOAD_SLOT);
      acc     = sample_valid && !m_full;
      exp_un  = 1'b0;
      if (load) begin
        words[m_frame] = m_full ? m_hold : 32'h0;
        exp_un = !m_full;
        m_full = 1'b0;
      end
      if (acc) begin
        m_full = 1'b1;
        m_hold = {sample_l, sample_r};
      end
      m_acc     = acc;
      exp_ready = !m_full;
      exp_bclk  = ((m_t / CD) % 2) == 1;
      exp_fs    = fall && (m_f >= 1) && (m_slot == 0);
      exp_ws    = (m_f >= 1) && (m_slot >= W);
      exp_data  = (m_f == 0) ? 1'b0 : frame_bit(m_frame, m_slot);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic go_to(input int target);
    while (m_t < target) tick();
  endtask

  // Compare process: every cycle on the falling clk_sys edge, and log what was sent per slot.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_en) begin
        check("bclk",         32'(i2s_bclk),     32'(exp_bclk));
        check("ws",           32'(i2s_ws),       32'(exp_ws));
        check("data",         32'(i2s_data),     32'(exp_data));
        check("frame_start",  32'(frame_start),  32'(exp_fs));
        check("underrun",     32'(underrun),     32'(exp_un));
        check("sample_ready", 32'(sample_ready), 32'(exp_ready));
        if (m_f >= 1) begin
          ck_tmp = obs_ws[m_frame]; ck_tmp[m_slot] = i2s_ws; obs_ws[m_frame] = ck_tmp;
`ifdef I2S_TX_LEFTJ_EN
          ck_tmp = obs_word[m_frame]; ck_tmp[31-m_slot] = i2s_data; obs_word[m_frame] = ck_tmp;
`else
          if (m_slot == 0) begin
            if (m_frame > 0) begin
              ck_tmp = obs_word[m_frame-1]; ck_tmp[0] = i2s_data; obs_word[m_frame-1] = ck_tmp;
            end
          end else begin
            ck_tmp = obs_word[m_frame]; ck_tmp[32-m_slot] = i2s_data; obs_word[m_frame] = ck_tmp;
          end
`endif
        end
      end
    end
  end

  int k;
  int n_under;
  int load7;

  initial begin
    for (int i = 0; i < 32; i++) begin
      obs_word[i] = 32'h0;
      obs_ws[i]   = 32'h0;
    end
    RESET = 1'b1; sample_valid = 1'b0; sample_l = 16'h0; sample_r = 16'h0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    RESET = 1'b0;

    // First frame pattern, accepted on the first cycle after reset.
`ifdef I2S_TX_LEFTJ_EN
    sample_l = 16'h8001;
`else
    sample_l = 16'hA5A5;
`endif
    sample_r = 16'h0F0F; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("ready_after_accept", 32'(sample_ready), 32'h0);
    go_to(2);  check("bclk_first_rise", 32'(i2s_bclk), 32'h1);
    go_to(4);  check("bclk_first_fall", 32'(i2s_bclk), 32'h0);
               check("fs_first_fall", 32'(frame_start), 32'h1);
    go_to(FRAME + 4);        check("fs_frame1", 32'(frame_start), 32'h1);
    go_to(FRAME + LOAD_OFF); check("underrun_pulse", 32'(underrun), 32'h1);
    go_to(FRAME + LOAD_OFF + 1); check("underrun_one_cycle", 32'(underrun), 32'h0);
    go_to(140);
`ifdef I2S_TX_LEFTJ_EN
    check("leftj_word0", obs_word[0], 32'h80010F0F);
`else
    check("i2s_word0", obs_word[0], 32'hA5A50F0F);
`endif
    check("ws_frame0", obs_ws[0], 32'hFFFF0000);

    // Backpressure: valid held high, new pair after each accept.
    k = 0; n_under = 0;
    sample_l = 16'h1100; sample_r = 16'h2200; sample_valid = 1'b1;
    while (m_t < 5 * FRAME + 20) begin
      tick();
      if (underrun) n_under++;
      if (m_acc) begin
        k++;
        sample_l = 16'(16'h1100 + k);
        sample_r = 16'(16'h2200 + k);
      end
    end
    sample_valid = 1'b0;
    check("bp_accepts", 32'(k), 32'd5);
    check("bp_no_underrun", 32'(n_under), 32'd0);
    check("underrun_frame_muted", obs_word[1], 32'h0);
    check("bp_word2", obs_word[2], 32'h11002200);
    check("bp_word3", obs_word[3], 32'h11012201);
    check("bp_word4", obs_word[4], 32'h11022202);

    // Same-cycle collision: valid appears exactly on the load edge with holding empty.
    load7 = 7 * FRAME + LOAD_OFF;
    go_to(load7 - 1);
    sample_l = 16'hC0DE; sample_r = 16'hBEEF; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("collision_underrun", 32'(underrun), 32'h1);
    check("collision_ready", 32'(sample_ready), 32'h0);
    go_to(9 * FRAME + 8);
    check("bp_word6", obs_word[6], 32'h11042204);
    check("collision_muted", obs_word[7], 32'h0);
    check("collision_next_frame", obs_word[8], 32'hC0DEBEEF);

    // Reset in slot 9 of frame 9.
    go_to(2 * CD * (32 * 9 + 9 + 1) + 1);
    RESET = 1'b1;
    tick();
    check("rst_mid_ready", 32'(sample_ready), 32'h1);
    check("rst_mid_outs", {27'h0, i2s_bclk, i2s_ws, i2s_data, frame_start, underrun}, 32'h0);
    tick();
    RESET = 1'b0;
    sample_l = 16'h1234; sample_r = 16'h8765; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    go_to(4);  check("rst_fs_restart", 32'(frame_start), 32'h1);
    go_to(2 * CD * (W + 1) - 1); check("rst_ws_left", 32'(i2s_ws), 32'h0);
    go_to(2 * CD * (W + 1));     check("rst_ws_right", 32'(i2s_ws), 32'h1);
    go_to(FRAME + LOAD_OFF + 8);
    check("rst_word0", obs_word[0], 32'h12348765);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
